// File: rtl/la_trace_decoder_if.sv
`timescale 1ns/1ps
// Trace-stream and sample-port bundle for the trace decoder.
// master: the upstream/downstream fabric side. slave: the decoder side.
interface la_trace_decoder_if #(
  parameter int pDATA_WIDTH = 32,
  parameter int pLA_WIDTH   = 24
);
  logic [pDATA_WIDTH-1:0] s_tdata;
  logic                   s_tvalid;
  logic                   s_tready;
  logic                   s_tlast;
  logic [1:0]             s_tuser;
  logic [pLA_WIDTH-1:0]   wave_data;
  logic                   wave_gap;
  logic                   wave_valid;
  logic                   wave_ready;

  modport master (
    output s_tdata, s_tvalid, s_tlast, s_tuser, wave_ready,
    input  s_tready, wave_data, wave_gap, wave_valid
  );

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, s_tuser, wave_ready,
    output s_tready, wave_data, wave_gap, wave_valid
  );
endinterface

// File: rtl/la_trace_decoder.sv
`timescale 1ns/1ps
// Run-length trace decoder: expands {rc, la_data} words into one sample per
// repeat on a ready/valid port. All-zero words become single gap markers;
// rc=0 with non-zero data is malformed and only raises a sticky error.
module la_trace_decoder #(
  parameter int pDATA_WIDTH = 32,
  parameter int pLA_WIDTH   = 24,
  parameter int pRC_WIDTH   = 8
) (
  input  logic                 axis_clk,
  input  logic                 axis_rst,
  input  logic                 dec_enable,
  la_trace_decoder_if.slave    bus,
  output logic [15:0]          pkt_count,
  output logic [15:0]          burst_count,
  output logic [31:0]          sample_count,
  output logic                 err_zero_rc
);

  logic [pRC_WIDTH-1:0] rem_q,    rem_d;
  logic [pLA_WIDTH-1:0] data_q,   data_d;
  logic                 gap_q,    gap_d;
  logic [15:0]          pkt_q,    pkt_d;
  logic [15:0]          burst_q,  burst_d;
  logic [31:0]          sample_q, sample_d;
  logic                 err_q,    err_d;

  logic                 busy;
  logic                 accept;
  logic                 handshake;
  logic [pRC_WIDTH-1:0] word_rc;
  logic [pLA_WIDTH-1:0] word_data;
  logic                 unused_tuser;

  assign unused_tuser = ^bus.s_tuser;

  assign word_rc   = bus.s_tdata[pDATA_WIDTH-1 -: pRC_WIDTH];
  assign word_data = bus.s_tdata[pLA_WIDTH-1:0];

  // Ready opens on the last pending sample so consecutive runs have no bubble.
  assign busy         = (rem_q != '0);
  assign bus.s_tready = dec_enable &
                        (!busy | ((rem_q == pRC_WIDTH'(1)) & bus.wave_ready));
  assign accept       = bus.s_tvalid & bus.s_tready;
  assign handshake    = busy & bus.wave_ready;

  assign bus.wave_valid = busy;
  assign bus.wave_data  = data_q;
  assign bus.wave_gap   = gap_q;
  assign pkt_count      = pkt_q;
  assign burst_count    = burst_q;
  assign sample_count   = sample_q;
  assign err_zero_rc    = err_q;

  // Next state: flush when disabled, otherwise a load overrides the decrement.
  always_comb begin
    rem_d    = rem_q;
    data_d   = data_q;
    gap_d    = gap_q;
    pkt_d    = pkt_q;
    burst_d  = burst_q;
    sample_d = sample_q;
    err_d    = err_q;
    if (!dec_enable) begin
      rem_d    = '0;
      data_d   = '0;
      gap_d    = 1'b0;
      pkt_d    = '0;
      burst_d  = '0;
      sample_d = '0;
      err_d    = 1'b0;
    end else begin
      if (handshake) begin
        rem_d = rem_q - pRC_WIDTH'(1);
        if (sample_q != 32'hFFFF_FFFF) begin
          sample_d = sample_q + 32'd1;
        end
      end
      if (accept) begin
        pkt_d = pkt_q + 16'd1;
        if (bus.s_tlast) begin
          burst_d = burst_q + 16'd1;
        end
        if (bus.s_tdata == '0) begin
          rem_d  = pRC_WIDTH'(1);
          data_d = '0;
          gap_d  = 1'b1;
        end else if (word_rc == '0) begin
          rem_d = '0;
          err_d = 1'b1;
        end else begin
          rem_d  = word_rc;
          data_d = word_data;
          gap_d  = 1'b0;
        end
      end
    end
  end

  // State registers, cleared asynchronously on reset.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      rem_q    <= '0;
      data_q   <= '0;
      gap_q    <= 1'b0;
      pkt_q    <= '0;
      burst_q  <= '0;
      sample_q <= '0;
      err_q    <= 1'b0;
    end else begin
      rem_q    <= rem_d;
      data_q   <= data_d;
      gap_q    <= gap_d;
      pkt_q    <= pkt_d;
      burst_q  <= burst_d;
      sample_q <= sample_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_la_trace_decoder.sv
`timescale 1ns/1ps
// Randomized and directed bench for la_trace_decoder. The reference keeps a
// queue of the samples still owed to the consumer plus plain integer counters.
module tb_la_trace_decoder;

  logic        axis_clk;
  logic        axis_rst;
  logic        dec_enable;
  logic [15:0] pkt_count;
  logic [15:0] burst_count;
  logic [31:0] sample_count;
  logic        err_zero_rc;

  la_trace_decoder_if #(.pDATA_WIDTH(32), .pLA_WIDTH(24)) bus ();

  la_trace_decoder #(
    .pDATA_WIDTH(32),
    .pLA_WIDTH(24),
    .pRC_WIDTH(8)
  ) dut (
    .axis_clk     (axis_clk),
    .axis_rst     (axis_rst),
    .dec_enable   (dec_enable),
    .bus          (bus),
    .pkt_count    (pkt_count),
    .burst_count  (burst_count),
    .sample_count (sample_count),
    .err_zero_rc  (err_zero_rc)
  );

  // Free-running clock, 10 ns period.
  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  int          checks;
  int          failures;
  int          cycle_no;
  int          ready_mode;
  bit          last_accepted;

  logic [24:0] exp_q[$];
  int unsigned m_pkt;
  int unsigned m_burst;
  longint      m_sample;
  bit          m_err;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d got=%h exp=%h", tag, cycle_no, got, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_pkt    = 0;
    m_burst  = 0;
    m_sample = 0;
    m_err    = 1'b0;
  endtask

  function automatic bit next_ready();
    case (ready_mode)
      0:       return 1'b1;
      1:       return (cycle_no % 2) == 0;
      default: return $urandom_range(0, 3) != 0;
    endcase
  endfunction

  // One clock cycle: drive at the falling edge, check, then advance the model
  // to what the next rising edge should produce.
  task automatic applyStimulus(input bit en, input bit tv, input logic [31:0] td,
                               input bit tl, input bit wr);
    bit          exp_valid;
    bit          exp_ready;
    bit          acc;
    bit          hs;
    logic [7:0]  rc;
    @(negedge axis_clk);
    dec_enable     = en;
    bus.s_tvalid   = tv;
    bus.s_tdata    = td;
    bus.s_tlast    = tl;
    bus.s_tuser    = 2'($urandom);
    bus.wave_ready = wr;
    #1;
    exp_valid = exp_q.size() != 0;
    exp_ready = en && (exp_q.size() == 0 || (exp_q.size() == 1 && wr));
    checkOutput("s_tready", 32'(bus.s_tready), 32'(exp_ready));
    checkOutput("wave_valid", 32'(bus.wave_valid), 32'(exp_valid));
    if (exp_valid) begin
      checkOutput("wave_data", 32'(bus.wave_data), 32'(exp_q[0][23:0]));
      checkOutput("wave_gap", 32'(bus.wave_gap), 32'(exp_q[0][24]));
    end
    checkOutput("pkt_count", 32'(pkt_count), m_pkt & 32'hFFFF);
    checkOutput("burst_count", 32'(burst_count), m_burst & 32'hFFFF);
    checkOutput("sample_count", sample_count, 32'(m_sample));
    checkOutput("err_zero_rc", 32'(err_zero_rc), 32'(m_err));

    acc = tv && exp_ready;
    hs  = exp_valid && wr;
    last_accepted = acc;
    if (!en) begin
      model_clear();
    end else begin
      if (hs) begin
        void'(exp_q.pop_front());
        if (m_sample != 64'h0_FFFF_FFFF) m_sample++;
      end
      if (acc) begin
        m_pkt++;
        if (tl) m_burst++;
        rc = td[31:24];
        if (td == 32'h0) begin
          exp_q.push_back(25'h1_000000);
        end else if (rc == 8'h00) begin
          m_err = 1'b1;
        end else begin
          for (int i = 0; i < int'(rc); i++) exp_q.push_back({1'b0, td[23:0]});
        end
      end
    end
    cycle_no++;
  endtask

  // Hold a word on the stream until it is taken, with a cycle budget.
  task automatic send_word(input logic [31:0] word, input bit tl);
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(1'b1, 1'b1, word, tl, next_ready());
      if (last_accepted) return;
    end
    checkOutput("send_timeout", 32'd0, 32'd1);
  endtask

  // Idle cycles with garbage on tdata to show it is ignored without valid.
  task automatic idle(input int n, input bit en);
    for (int i = 0; i < n; i++) begin
      applyStimulus(en, 1'b0, $urandom, 1'($urandom), next_ready());
    end
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic reset_pulse();
    @(negedge axis_clk);
    #2;
    axis_rst = 1'b1;
    #1;
    model_clear();
    checkOutput("rst_wave_valid", 32'(bus.wave_valid), 32'd0);
    checkOutput("rst_wave_data", 32'(bus.wave_data), 32'd0);
    checkOutput("rst_wave_gap", 32'(bus.wave_gap), 32'd0);
    checkOutput("rst_pkt", 32'(pkt_count), 32'd0);
    checkOutput("rst_burst", 32'(burst_count), 32'd0);
    checkOutput("rst_sample", sample_count, 32'd0);
    checkOutput("rst_err", 32'(err_zero_rc), 32'd0);
    #1;
    axis_rst = 1'b0;
  endtask

  initial begin
    logic [31:0] word;
    int          r;
    checks     = 0;
    failures   = 0;
    cycle_no   = 0;
    ready_mode = 0;
    model_clear();
    axis_rst       = 1'b1;
    dec_enable     = 1'b0;
    bus.s_tvalid   = 1'b0;
    bus.s_tdata    = 32'h0;
    bus.s_tlast    = 1'b0;
    bus.s_tuser    = 2'b00;
    bus.wave_ready = 1'b0;
    #2;
    checkOutput("init_wave_valid", 32'(bus.wave_valid), 32'd0);
    checkOutput("init_wave_data", 32'(bus.wave_data), 32'd0);
    checkOutput("init_s_tready", 32'(bus.s_tready), 32'd0);
    checkOutput("init_sample", sample_count, 32'd0);
    @(negedge axis_clk);
    axis_rst = 1'b0;

    // Single run of three samples.
    send_word(32'h0300ABCD, 1'b0);
    idle(5, 1'b1);

    // Back-to-back runs, including the longest repeat count.
    send_word(32'h02000001, 1'b0);
    send_word(32'h01000002, 1'b0);
    send_word(32'hFF000003, 1'b0);
    idle(260, 1'b1);

    // Consumer stalling every other cycle.
    ready_mode = 1;
    send_word(32'h04000055, 1'b0);
    idle(10, 1'b1);

    // Null packet followed by a normal word.
    ready_mode = 0;
    send_word(32'h00000000, 1'b0);
    send_word(32'h0100FFFF, 1'b0);
    idle(3, 1'b1);

    // Malformed word: no samples, sticky error.
    send_word(32'h00000010, 1'b0);
    idle(3, 1'b1);

    // Burst, flush mid-run, then a reset mid-run.
    send_word(32'h05000001, 1'b0);
    send_word(32'h05000002, 1'b0);
    send_word(32'h05000003, 1'b1);
    idle(2, 1'b1);
    idle(2, 1'b0);
    send_word(32'h06000077, 1'b1);
    idle(2, 1'b1);
    reset_pulse();
    idle(3, 1'b1);

    // Randomized traffic with random consumer back-pressure.
    ready_mode = 2;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        word = 32'h0;
      end else if (r == 1) begin
        word = {8'h00, 24'($urandom_range(1, 24'hFFFFFF))};
      end else if (r == 2) begin
        word = {8'($urandom_range(7, 40)), 24'($urandom)};
      end else begin
        word = {8'($urandom_range(1, 6)), 24'($urandom)};
      end
      send_word(word, ($urandom_range(0, 3) == 0));
      idle($urandom_range(0, 2), 1'b1);
      if ($urandom_range(0, 49) == 0) idle(1, 1'b0);
    end
    ready_mode = 0;
    idle(60, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
